// File: rtl/branch_pc_unit_if.sv
// Fetch/decode handshake bundle for the branch PC unit.
// The unit drives pc/pc_valid/instr_ready and consumes the decoded instruction fields and eq.
interface branch_pc_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pc_ready;
  logic            instr_valid;
  logic            instr_ready;
  logic [1:0]      branch_op;
  logic [XLEN-1:0] imm;
  logic            eq;

  modport master (
    output pc, pc_valid, instr_ready,
    input  pc_ready, instr_valid, branch_op, imm, eq
  );

  modport slave (
    input  pc, pc_valid, instr_ready,
    output pc_ready, instr_valid, branch_op, imm, eq
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Architectural PC holder: issues PC to fetch, resolves BEQ/BNE from the eq comparator,
// halts on misaligned taken targets and keeps saturating branch statistics.
module branch_pc_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_pc_unit_if.master    bus,
  output logic                halted_o,
  output logic [XLEN-1:0]     misalign_addr_o,
  output logic [CNT_W-1:0]    branch_count_o,
  output logic [CNT_W-1:0]    taken_count_o
);

  localparam logic [1:0] OP_BEQ = 2'b01;
  localparam logic [1:0] OP_BNE = 2'b10;

  typedef enum logic [1:0] {S_RESET, S_ISSUE, S_WAIT, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              instr_ready_q, instr_ready_d;
  logic              halted_q, halted_d;
  logic [XLEN-1:0]   misalign_q, misalign_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;

  logic              is_beq, is_bne, is_br, taken, misaligned;
  logic [XLEN-1:0]   target, seq_pc;

  // Branch resolution datapath; only consumed while in S_WAIT.
  always_comb begin
    is_beq     = (bus.branch_op == OP_BEQ);
    is_bne     = (bus.branch_op == OP_BNE);
    is_br      = is_beq | is_bne;
    taken      = (is_beq & bus.eq) | (is_bne & ~bus.eq);
    target     = pc_q + bus.imm;
    seq_pc     = pc_q + XLEN'(4);
    misaligned = taken & (target[1:0] != 2'b00);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    halted_d   = halted_q;
    misalign_d = misalign_q;
    bcnt_d     = bcnt_q;
    tcnt_d     = tcnt_q;

    case (state_q)
      S_RESET: state_d = S_ISSUE;
      S_ISSUE: if (bus.pc_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.instr_valid) begin
          if (is_br && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_W'(1);
          if (taken && (tcnt_q != '1)) tcnt_d = tcnt_q + CNT_W'(1);
          if (misaligned) begin
            halted_d   = 1'b1;
            misalign_d = target;
            state_d    = S_HALT;
          end else begin
            pc_d    = taken ? target : seq_pc;
            state_d = S_ISSUE;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase

    // Handshake flags follow the state being entered so they are valid from its first cycle.
    pc_valid_d    = (state_d == S_ISSUE);
    instr_ready_d = (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RESET;
      pc_q          <= RESET_PC;
      pc_valid_q    <= 1'b0;
      instr_ready_q <= 1'b0;
      halted_q      <= 1'b0;
      misalign_q    <= '0;
      bcnt_q        <= '0;
      tcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      instr_ready_q <= instr_ready_d;
      halted_q      <= halted_d;
      misalign_q    <= misalign_d;
      bcnt_q        <= bcnt_d;
      tcnt_q        <= tcnt_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.instr_ready = instr_ready_q;
  assign halted_o        = halted_q;
  assign misalign_addr_o = misalign_q;
  assign branch_count_o  = bcnt_q;
  assign taken_count_o   = tcnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: main instance at RESET_PC=0x1000, second with CNT_W=4.
module tb_branch_pc_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_pc_unit_if #(.XLEN(64)) bus  ();
  branch_pc_unit_if #(.XLEN(64)) bus2 ();

  logic        halted, halted2;
  logic [63:0] mis_addr, mis_addr2;
  logic [15:0] bcnt, tcnt;
  logic [3:0]  bcnt2, tcnt2;

  branch_pc_unit #(.XLEN(64), .RESET_PC(64'h1000), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .halted_o(halted), .misalign_addr_o(mis_addr),
    .branch_count_o(bcnt), .taken_count_o(tcnt)
  );

  branch_pc_unit #(.XLEN(64), .RESET_PC(64'h0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .halted_o(halted2), .misalign_addr_o(mis_addr2),
    .branch_count_o(bcnt2), .taken_count_o(tcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for instr_ready, presents one instruction for a single cycle.
  task automatic step_instr(input logic [1:0] op, input logic e, input logic [63:0] im);
    int n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL step_timeout: instr_ready=%b after %0d cycles, required 1", bus.instr_ready, n);
    end else begin
      bus.instr_valid = 1'b1; bus.branch_op = op; bus.eq = e; bus.imm = im;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0; bus.branch_op = 2'b00; bus.eq = 1'b0; bus.imm = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pc_ready = 1'b1; bus.instr_valid = 1'b0; bus.branch_op = 2'b00; bus.imm = '0; bus.eq = 1'b0;
    bus2.pc_ready = 1'b0; bus2.instr_valid = 1'b0; bus2.branch_op = 2'b00; bus2.imm = '0; bus2.eq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.pc !== 64'h1000) begin failures++; $display("FAIL reset_pc: got %h required %h", bus.pc, 64'h1000); end
    checks++; if (bus.pc_valid !== 1'b0) begin failures++; $display("FAIL reset_pc_valid: got %b required 0", bus.pc_valid); end
    checks++; if (bus.instr_ready !== 1'b0) begin failures++; $display("FAIL reset_instr_ready: got %b required 0", bus.instr_ready); end
    checks++; if (halted !== 1'b0 || mis_addr !== 64'h0) begin failures++; $display("FAIL reset_halt: halted=%b addr=%h required 0/0", halted, mis_addr); end
    checks++; if (bcnt !== 16'h0 || tcnt !== 16'h0) begin failures++; $display("FAIL reset_counts: got %h/%h required 0/0", bcnt, tcnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 64'h1000) begin failures++; $display("FAIL release_issue: pc_valid=%b pc=%h required 1/1000", bus.pc_valid, bus.pc); end
    step_instr(2'b00, 1'b0, 64'h0);
    checks++; if (bus.pc !== 64'h1004) begin failures++; $display("FAIL seq_pc: got %h required %h", bus.pc, 64'h1004); end
    checks++; if (bcnt !== 16'h0 || tcnt !== 16'h0) begin failures++; $display("FAIL seq_counts: got %h/%h required 0/0", bcnt, tcnt); end
  endtask

  task automatic test_branches();
    step_instr(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    checks++; if (bus.pc !== 64'h0FFC) begin failures++; $display("FAIL beq_taken_pc: got %h required %h", bus.pc, 64'h0FFC); end
    checks++; if (bcnt !== 16'd1 || tcnt !== 16'd1) begin failures++; $display("FAIL beq_taken_counts: got %0d/%0d required 1/1", bcnt, tcnt); end
    step_instr(2'b10, 1'b1, 64'h100);
    checks++; if (bus.pc !== 64'h1000) begin failures++; $display("FAIL bne_nt_pc: got %h required %h", bus.pc, 64'h1000); end
    checks++; if (bcnt !== 16'd2 || tcnt !== 16'd1) begin failures++; $display("FAIL bne_nt_counts: got %0d/%0d required 2/1", bcnt, tcnt); end
    step_instr(2'b11, 1'b1, 64'h40);
    checks++; if (bus.pc !== 64'h1004 || bcnt !== 16'd2 || tcnt !== 16'd1) begin failures++; $display("FAIL op11_as_none: pc=%h cnt=%0d/%0d required 1004 2/1", bus.pc, bcnt, tcnt); end
    step_instr(2'b10, 1'b0, 64'h10);
    checks++; if (bus.pc !== 64'h1014 || bcnt !== 16'd3 || tcnt !== 16'd2) begin failures++; $display("FAIL bne_taken: pc=%h cnt=%0d/%0d required 1014 3/2", bus.pc, bcnt, tcnt); end
    step_instr(2'b01, 1'b0, 64'h40);
    checks++; if (bus.pc !== 64'h1018 || bcnt !== 16'd4 || tcnt !== 16'd2) begin failures++; $display("FAIL beq_nt: pc=%h cnt=%0d/%0d required 1018 4/2", bus.pc, bcnt, tcnt); end
  endtask

  task automatic test_wrap();
    step_instr(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_EFE4);
    checks++; if (bus.pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_setup: got %h required FFFFFFFFFFFFFFFC", bus.pc); end
    step_instr(2'b00, 1'b0, 64'h0);
    checks++; if (bus.pc !== 64'h0) begin failures++; $display("FAIL seq_wrap: got %h required 0", bus.pc); end
    step_instr(2'b00, 1'b0, 64'h0);
    step_instr(2'b00, 1'b0, 64'h0);
    step_instr(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
    checks++; if (bus.pc !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL target_wrap: got %h required FFFFFFFFFFFFFFF8", bus.pc); end
    checks++; if (bcnt !== 16'd6 || tcnt !== 16'd4) begin failures++; $display("FAIL wrap_counts: got %0d/%0d required 6/4", bcnt, tcnt); end
  endtask

  task automatic test_stall();
    bus.pc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.instr_valid = 1'b1; bus.branch_op = 2'b01; bus.eq = 1'b1; bus.imm = 64'h40;
      @(posedge clk); #1;
      checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 64'hFFFF_FFFF_FFFF_FFF8 || bus.instr_ready !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d]: pc_valid=%b pc=%h instr_ready=%b required 1/FFFFFFFFFFFFFFF8/0", i, bus.pc_valid, bus.pc, bus.instr_ready);
      end
    end
    bus.instr_valid = 1'b0; bus.branch_op = 2'b00; bus.eq = 1'b0; bus.imm = '0;
    checks++; if (bcnt !== 16'd6 || tcnt !== 16'd4) begin failures++; $display("FAIL stall_counts: got %0d/%0d required 6/4", bcnt, tcnt); end
    bus.pc_ready = 1'b1;
  endtask

  task automatic test_halt();
    step_instr(2'b00, 1'b0, 64'h0);
    step_instr(2'b00, 1'b0, 64'h0);
    step_instr(2'b01, 1'b1, 64'h2000);
    checks++; if (bus.pc !== 64'h2000) begin failures++; $display("FAIL halt_setup: got %h required 2000", bus.pc); end
    step_instr(2'b01, 1'b1, 64'h6);
    checks++; if (halted !== 1'b1 || mis_addr !== 64'h2006) begin failures++; $display("FAIL misalign: halted=%b addr=%h required 1/2006", halted, mis_addr); end
    checks++; if (bcnt !== 16'd8 || tcnt !== 16'd6) begin failures++; $display("FAIL misalign_counts: got %0d/%0d required 8/6", bcnt, tcnt); end
    bus.instr_valid = 1'b1; bus.branch_op = 2'b01; bus.eq = 1'b1; bus.imm = 64'h4;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.pc !== 64'h2000 || bus.pc_valid !== 1'b0 || bus.instr_ready !== 1'b0 || halted !== 1'b1) begin
        failures++; $display("FAIL halt_sticky[%0d]: pc=%h pc_valid=%b instr_ready=%b halted=%b required 2000/0/0/1", i, bus.pc, bus.pc_valid, bus.instr_ready, halted);
      end
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b0; bus.branch_op = 2'b00; bus.eq = 1'b0; bus.imm = '0;
    rst_n = 1'b0; #1;
    checks++; if (bus.pc !== 64'h1000 || halted !== 1'b0 || bcnt !== 16'h0) begin failures++; $display("FAIL halt_recover: pc=%h halted=%b bcnt=%0d required 1000/0/0", bus.pc, halted, bcnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 64'h1000) begin failures++; $display("FAIL recover_issue: pc_valid=%b pc=%h required 1/1000", bus.pc_valid, bus.pc); end
  endtask

  task automatic test_async_reset();
    step_instr(2'b01, 1'b1, 64'h8);
    checks++; if (bus.pc !== 64'h1008 || bcnt !== 16'd1 || tcnt !== 16'd1) begin failures++; $display("FAIL pre_abort: pc=%h cnt=%0d/%0d required 1008 1/1", bus.pc, bcnt, tcnt); end
    @(posedge clk); #1;
    checks++; if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL enter_wait: instr_ready=%b required 1", bus.instr_ready); end
    bus.instr_valid = 1'b1; bus.branch_op = 2'b01; bus.eq = 1'b1; bus.imm = 64'h20;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.pc !== 64'h1000 || bus.pc_valid !== 1'b0 || bus.instr_ready !== 1'b0 || halted !== 1'b0 ||
                  mis_addr !== 64'h0 || bcnt !== 16'h0 || tcnt !== 16'h0) begin
      failures++; $display("FAIL async_abort: pc=%h pv=%b ir=%b h=%b ma=%h cnt=%0d/%0d required 1000/0/0/0/0 0/0", bus.pc, bus.pc_valid, bus.instr_ready, halted, mis_addr, bcnt, tcnt);
    end
    bus.instr_valid = 1'b0; bus.branch_op = 2'b00; bus.eq = 1'b0; bus.imm = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int n;
    bus2.pc_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      while (bus2.instr_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) begin
        checks++; failures++;
        $display("FAIL sat_timeout[%0d]: instr_ready=%b required 1", k, bus2.instr_ready);
        break;
      end
      bus2.instr_valid = 1'b1; bus2.branch_op = 2'b01; bus2.eq = 1'b1; bus2.imm = 64'h4;
      @(posedge clk); #1;
      bus2.instr_valid = 1'b0;
      if (k == 14) begin
        checks++; if (bcnt2 !== 4'hF || tcnt2 !== 4'hF) begin failures++; $display("FAIL sat_reach: got %h/%h required F/F", bcnt2, tcnt2); end
      end
    end
    checks++; if (bcnt2 !== 4'hF || tcnt2 !== 4'hF) begin failures++; $display("FAIL sat_hold: got %h/%h required F/F", bcnt2, tcnt2); end
    checks++; if (bus2.pc !== 64'h50) begin failures++; $display("FAIL sat_pc: got %h required 50", bus2.pc); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_branches();
    test_wrap();
    test_stall();
    test_halt();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
